exchange_control: RTL
=====================

Name: exchange_control

Overview:
- Initiator side of the replica-exchange command interface consumed by every metropolis replica.
- On request, it snapshots all replica total distances and evaluates the exchange criterion for alternating even/odd neighbour pairs, one pair per cycle.
- It then drives a one-cycle PREV/FOLW/NOP command vector to all replicas.
- It sits in the top-level replica array, beside the per-replica metropolis instances and the random source.

Parameters:
- N_REPLICA, 32, number of replicas; replica id k has beta = (k+1)*DBETA.
- DATA_W, 27, width of total_data_t (distance, Q.17 fixed point).
- DBETA, 1, integer beta step, identical to the package dbeta.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- exchange_start  in  1  single-cycle request to run one exchange round.
- distance  in  N_REPLICA*DATA_W  packed total distances; replica k occupies bits [k*DATA_W +: DATA_W], unsigned.
- nlog_r  in  32  -ln(u) of a uniform random, unsigned Q15.17; consumed when random_ready=1.
- random_ready  out  1  high in each SCAN cycle; nlog_r is sampled that cycle.
- busy  out  1  high from the cycle after exchange_start until command_valid, inclusive.
- command  out  N_REPLICA*2  per-replica exchange_command_t, encoded NOP=0, PREV=1, FOLW=2; slot k is bits [2k +: 2].
- command_valid  out  1  one-cycle strobe; command is non-NOP only in this cycle.
- parity  out  1  pair set for the current/next round: 0 = pairs (0,1),(2,3)…; 1 = pairs (1,2),(3,4)….
- exchange_count  out  16  saturating count of accepted exchanges since reset.

Behaviour:
- Reset values: state IDLE, all command slots NOP, command_valid=0, busy=0, random_ready=0, parity=0, exchange_count=0, accept bits cleared.
- Reset mid-round aborts the round; no command_valid is produced.
- FSM states: IDLE, SCAN, ISSUE.
- IDLE: exchange_start=1 latches distance into an internal snapshot array and sets pair index k=parity.
  - If no pair exists (k+1 >= N_REPLICA), go directly to ISSUE; otherwise go to SCAN.
  - exchange_start while not IDLE is ignored, not queued.
- SCAN: each cycle evaluates pair (k,k+1) from the snapshot and samples nlog_r.
  - dE = E[k+1] - E[k], signed DATA_W+1 bits.
  - arg = dE*DBETA, signed, at least DATA_W+18 bits, no truncation.
  - accept[k] = (arg >= 0) || (arg + nlog_r >= 0). Equality accepts.
  - Then k += 2; when k+1 >= N_REPLICA, go to ISSUE.
- ISSUE: for one cycle, command_valid=1 and for each accepted pair k: slot k = FOLW, slot k+1 = PREV; all other slots NOP.
  - exchange_count increments by the number of accepted pairs, saturating at 16'hFFFF.
  - parity toggles and the FSM returns to IDLE.
  - The cycle after ISSUE, command is all NOP again.
- Latency: exchange_start sampled at cycle t.
  - SCAN occupies cycles t+1 … t+P, with P = pairs for the current parity (even: floor(N/2), odd: floor((N-1)/2)).
  - command_valid is asserted at t+P+1.
- random_ready equals (state==SCAN); exactly P values are consumed per round.
- Changes on distance after the start cycle do not affect the decision.
- Accept bits are cleared on entry to SCAN; stale results never leak into a later round.
- Downstream contract: replicas apply PREV/FOLW in the command_valid cycle. Callers do not assert distance_shift in the same cycle.

Test Plan:
- Even round, forward gaps: N_REPLICA=4, DBETA=1, E=[10,20,30,40]<<17, parity=0, nlog_r=0, start → 2 SCAN cycles, then command=[FOLW,PREV,FOLW,PREV] (slot 0 first), exchange_count=2, parity=1.
- Odd round, same E: start → 1 SCAN cycle, command=[NOP,FOLW,PREV,NOP], exchange_count=3, parity=0.
- Reject and accept boundary: E=[20,10,..]<<17, pair (0,1), dE=-10<<17.
  - nlog_r=5<<17 → slots 0,1 NOP.
  - nlog_r=10<<17 → slots 0,1 = FOLW,PREV (equality accepts).
  - nlog_r=(10<<17)-1 → reject.
- Snapshot and ignore rules:
  - Change distance the cycle after start → decision uses the latched values.
  - Pulse exchange_start while busy → ignored; exactly one command_valid results.
- Reset mid-SCAN: assert reset at t+1 → no command_valid, busy=0, parity=0, count unchanged at 0. A new start runs a clean even round.
- Counter saturation: preload by running rounds (or force) to 16'hFFFE, then a round with 2 accepts → 16'hFFFF.

Source files
------------

// File: rtl/exchange_control.sv
// Replica-exchange initiator: snapshots replica distances, evaluates the Metropolis
// exchange criterion for alternating neighbour pairs, then issues one PREV/FOLW/NOP command vector.
module exchange_control #(
    parameter int unsigned N_REPLICA = 32,
    parameter int unsigned DATA_W    = 27,
    parameter int unsigned DBETA     = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          exchange_start,
    input  logic [N_REPLICA*DATA_W-1:0]   distance,
    input  logic [31:0]                   nlog_r,
    output logic                          random_ready,
    output logic                          busy,
    output logic [N_REPLICA*2-1:0]        command,
    output logic                          command_valid,
    output logic                          parity,
    output logic [15:0]                   exchange_count
);

    localparam int unsigned IDX_W = (N_REPLICA > 1) ? $clog2(N_REPLICA) : 1;
    localparam int unsigned K_W   = $clog2(N_REPLICA + 3) + 1;
    localparam int unsigned ARG_W = DATA_W + 18;
    localparam int unsigned SUM_W = ((ARG_W > 33) ? ARG_W : 33) + 1;

    localparam logic [1:0] CMD_NOP  = 2'd0;
    localparam logic [1:0] CMD_PREV = 2'd1;
    localparam logic [1:0] CMD_FOLW = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_ISSUE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [K_W-1:0]          k_q, k_d;
    logic [DATA_W-1:0]       snap_q [N_REPLICA];
    logic [DATA_W-1:0]       snap_d [N_REPLICA];
    logic [N_REPLICA-1:0]    accept_q, accept_d;
    logic                    parity_q, parity_d;
    logic [15:0]             count_q, count_d;
    logic                    random_ready_q, random_ready_d;
    logic                    busy_q, busy_d;
    logic                    command_valid_q, command_valid_d;
    logic [N_REPLICA*2-1:0]  command_q, command_d;

    logic [DATA_W-1:0]       e_lo, e_hi;
    logic signed [DATA_W:0]  d_e;
    logic signed [ARG_W-1:0] arg;
    logic signed [SUM_W-1:0] arg_plus_r;
    logic                    pair_accept;
    logic [16:0]             count_sum;

    // Exchange criterion for the pair currently addressed by k, with unsigned energies widened before subtracting
    always_comb begin
        e_lo        = snap_q[IDX_W'(k_q)];
        e_hi        = snap_q[IDX_W'(k_q + K_W'(1))];
        d_e         = $signed({1'b0, e_hi}) - $signed({1'b0, e_lo});
        arg         = ARG_W'(d_e) * $signed(ARG_W'(DBETA));
        arg_plus_r  = SUM_W'(arg) + $signed(SUM_W'(nlog_r));
        pair_accept = !arg[ARG_W-1] || !arg_plus_r[SUM_W-1];
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        snap_d    = snap_q;
        accept_d  = accept_q;
        parity_d  = parity_q;
        count_d   = count_q;
        count_sum = 17'(count_q);

        case (state_q)
            ST_IDLE: begin
                if (exchange_start) begin
                    for (int unsigned i = 0; i < N_REPLICA; i++) begin
                        snap_d[i] = distance[i*DATA_W +: DATA_W];
                    end
                    k_d      = K_W'(parity_q);
                    accept_d = '0;
                    state_d  = ((K_W'(parity_q) + K_W'(1)) >= K_W'(N_REPLICA)) ? ST_ISSUE : ST_SCAN;
                end
            end
            ST_SCAN: begin
                accept_d[IDX_W'(k_q)] = pair_accept;
                k_d = k_q + K_W'(2);
                if ((k_q + K_W'(3)) >= K_W'(N_REPLICA)) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                for (int unsigned i = 0; i < N_REPLICA; i++) begin
                    count_sum = count_sum + 17'(accept_q[i]);
                end
                count_d  = count_sum[16] ? 16'hFFFF : count_sum[15:0];
                parity_d = ~parity_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        random_ready_d  = (state_d == ST_SCAN);
        busy_d          = (state_d != ST_IDLE);
        command_valid_d = (state_d == ST_ISSUE);

        // Command is built from the final accept bits so the last scanned pair lands in the issue cycle
        command_d = '0;
        if (command_valid_d) begin
            for (int unsigned i = 0; i + 1 < N_REPLICA; i++) begin
                if (accept_d[i]) begin
                    command_d[2*i +: 2]     = CMD_FOLW;
                    command_d[2*i + 2 +: 2] = CMD_PREV;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            k_q             <= '0;
            snap_q          <= '{default: '0};
            accept_q        <= '0;
            parity_q        <= 1'b0;
            count_q         <= '0;
            random_ready_q  <= 1'b0;
            busy_q          <= 1'b0;
            command_valid_q <= 1'b0;
            command_q       <= {N_REPLICA{CMD_NOP}};
        end else begin
            state_q         <= state_d;
            k_q             <= k_d;
            snap_q          <= snap_d;
            accept_q        <= accept_d;
            parity_q        <= parity_d;
            count_q         <= count_d;
            random_ready_q  <= random_ready_d;
            busy_q          <= busy_d;
            command_valid_q <= command_valid_d;
            command_q       <= command_d;
        end
    end

    assign random_ready   = random_ready_q;
    assign busy           = busy_q;
    assign command        = command_q;
    assign command_valid  = command_valid_q;
    assign parity         = parity_q;
    assign exchange_count = count_q;

endmodule
